// File: rtl/ysyx_23060077_sysu_pkg.sv
// rtl/ysyx_23060077_sysu_pkg.sv - shared state encodings, CSR funct3 codes and widths for the system unit
package ysyx_23060077_sysu_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int CSR_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } sysu_state_t;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Set/clear with a zero source register (or zimm) is a pure read: no CSR write side effects.
    function automatic logic csr_writes(input logic [2:0] f3, input logic [4:0] rs1);
        logic set_or_clear;
        set_or_clear = (f3[1:0] == F3_CSRRS[1:0]) || (f3[1:0] == F3_CSRRC[1:0]);
        return !(set_or_clear && (rs1 == 5'd0));
    endfunction

endpackage

// File: rtl/ysyx_23060077_sysu.sv
// rtl/ysyx_23060077_sysu.sv - system-instruction unit: drains memory, issues CSR/ecall/mret, returns writeback
// Optional ebreak halt output enabled by defining SYSU_EBREAK_HALT_EN.
module ysyx_23060077_sysu
    import ysyx_23060077_sysu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [2:0]                in_funct3,
    input  logic [CSR_ADDR_WIDTH-1:0] in_csr_addr,
    input  logic [4:0]                in_rs1_field,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [4:0]                in_rd,
    input  logic                      in_is_ecall,
    input  logic                      in_is_mret,
    input  logic                      in_is_ebreak,
    input  logic                      lsu_idle,
    output logic [CSR_ADDR_WIDTH-1:0] csr_rd_addr,
    output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr,
    output logic [DATA_WIDTH-1:0]     csr_wr_data,
    output logic                      sys,
    output logic [2:0]                funct3,
    output logic [DATA_WIDTH-1:0]     csr_pc,
    output logic                      csr_ecall_o,
    output logic                      csr_mret_o,
    input  logic [DATA_WIDTH-1:0]     csr_rd_data,
    input  logic [DATA_WIDTH-1:0]     csr_mtvec,
    input  logic [DATA_WIDTH-1:0]     csr_mepc,
    output logic                      out_valid,
    output logic [4:0]                out_rd,
    output logic [DATA_WIDTH-1:0]     out_wdata,
    output logic                      out_wen,
    input  logic                      out_ready,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      err_timeout
`ifdef SYSU_EBREAK_HALT_EN
    ,
    output logic                      halt
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    sysu_state_t state_q, state_n;

    logic [DATA_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]     rs1_data_q;
    logic [2:0]                f3_q;
    logic [CSR_ADDR_WIDTH-1:0] addr_q;
    logic [4:0]                rs1_q;
    logic [4:0]                rd_q;
    logic                      ecall_q;
    logic                      mret_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     rpc_q;
    logic                      wen_q;
    logic                      redir_q;
    logic                      err_q;

    logic is_csr;
    logic drain_timeout;
    logic in_exec;

    assign is_csr        = (f3_q[1:0] != 2'b00);
    assign drain_timeout = !lsu_idle && (cnt_q == CNT_MAX);

`ifdef SYSU_EBREAK_HALT_EN
    logic ebreak_q;
    logic halt_q;
    assign halt = halt_q;
`else
    logic unused_ebreak;
    assign unused_ebreak = in_is_ebreak;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            rs1_data_q <= '0;
            f3_q       <= '0;
            addr_q     <= '0;
            rs1_q      <= '0;
            rd_q       <= '0;
            ecall_q    <= 1'b0;
            mret_q     <= 1'b0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            rpc_q      <= '0;
            wen_q      <= 1'b0;
            redir_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef SYSU_EBREAK_HALT_EN
            ebreak_q   <= 1'b0;
            halt_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (in_valid) begin
                        pc_q       <= in_pc;
                        rs1_data_q <= in_rs1_data;
                        f3_q       <= in_funct3;
                        addr_q     <= in_csr_addr;
                        rs1_q      <= in_rs1_field;
                        rd_q       <= in_rd;
                        ecall_q    <= in_is_ecall;
                        mret_q     <= in_is_mret;
`ifdef SYSU_EBREAK_HALT_EN
                        ebreak_q   <= in_is_ebreak;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (drain_timeout) begin
                        err_q <= 1'b1;
                    end else if (!lsu_idle) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_EXEC: begin
                    wdata_q <= is_csr ? csr_rd_data : '0;
                    wen_q   <= is_csr && (rd_q != 5'd0);
                    redir_q <= !is_csr && (ecall_q || mret_q);
                    if (!is_csr && ecall_q) begin
                        rpc_q <= csr_mtvec;
                    end else if (!is_csr && mret_q) begin
                        rpc_q <= csr_mepc;
                    end else begin
                        rpc_q <= '0;
                    end
`ifdef SYSU_EBREAK_HALT_EN
                    if (!is_csr && ebreak_q) begin
                        halt_q <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_n = ST_DRAIN;
            ST_DRAIN: if (lsu_idle || drain_timeout) state_n = ST_EXEC;
            ST_EXEC:  state_n = ST_RESP;
            ST_RESP:  if (out_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Pulses are gated by reset so a reset landing on EXEC produces no side effects in the CSR file.
    always_comb begin
        in_exec        = (state_q == ST_EXEC) && !reset;
        in_ready       = (state_q == ST_IDLE);
        csr_rd_addr    = addr_q;
        csr_wr_addr    = addr_q;
        csr_wr_data    = f3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_q} : rs1_data_q;
        sys            = in_exec && is_csr && csr_writes(f3_q, rs1_q);
        funct3         = sys ? f3_q : 3'b000;
        csr_ecall_o    = in_exec && !is_csr && ecall_q;
        csr_mret_o     = in_exec && !is_csr && mret_q;
        csr_pc         = csr_ecall_o ? pc_q : '0;
        out_valid      = (state_q == ST_RESP);
        out_rd         = out_valid ? rd_q : 5'd0;
        out_wdata      = out_valid ? wdata_q : '0;
        out_wen        = out_valid && wen_q;
        redirect_valid = out_valid && redir_q;
        redirect_pc    = out_valid ? rpc_q : '0;
        err_timeout    = err_q;
    end

endmodule
